// File: rtl/instruction_fetcher.sv
// Instruction fetcher: walks the PC, fetches one instruction at a time from
// the icache, asks the branch predictor about conditional branches, and
// hands each instruction with its prediction to the issue queue. Only one
// fetch is ever in flight; redirects from the RoB discard stale responses.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_en,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_en,
  input  logic [31:0] icache_resp_inst,
  output logic        bp_query_en,
  output logic [31:0] bp_query_pc,
  input  logic        bp_resp_en,
  input  logic        bp_resp_taken,
  input  logic        downstream_full,
  output logic        inst_out_en,
  output logic [31:0] inst_out,
  output logic [31:0] inst_out_pc,
  output logic        inst_out_pred_taken,
  input  logic        flush_en,
  input  logic [31:0] flush_pc
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_INST = 3'd1;
  localparam logic [2:0] WAIT_PRED = 3'd2;
  localparam logic [2:0] OUTPUT    = 3'd3;
  localparam logic [2:0] DISCARD_I = 3'd4;
  localparam logic [2:0] DISCARD_P = 3'd5;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [2:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] inst_r, inst_s;
  logic        pred_r, pred_s;
  logic        req_en_r, req_en_s;
  logic [31:0] req_addr_r, req_addr_s;
  logic        query_en_r, query_en_s;
  logic [31:0] query_pc_r, query_pc_s;
  logic        out_en_r, out_en_s;
  logic [31:0] out_inst_r, out_inst_s;
  logic [31:0] out_pc_r, out_pc_s;
  logic        out_pred_r, out_pred_s;
  logic [31:0] j_imm_s, b_imm_s, next_pc_s;

  // Sign-extended jump and branch offsets of the latched instruction.
  assign j_imm_s = {{12{inst_r[31]}}, inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};
  assign b_imm_s = {{20{inst_r[31]}}, inst_r[7], inst_r[30:25], inst_r[11:8], 1'b0};

  // Pulses are held in their registers while frozen and only shown when ready,
  // so a request raised just before a stall is still seen exactly once.
  assign icache_req_en       = req_en_r & rdy_in;
  assign icache_req_addr     = req_addr_r;
  assign bp_query_en         = query_en_r & rdy_in;
  assign bp_query_pc         = query_pc_r;
  assign inst_out_en         = out_en_r & rdy_in;
  assign inst_out            = out_inst_r;
  assign inst_out_pc         = out_pc_r;
  assign inst_out_pred_taken = out_pred_r;

  // Next PC after the latched instruction, following the recorded prediction.
  always_comb begin
    next_pc_s = pc_r + 32'd4;
    case (inst_r[6:0])
      OP_JAL: begin
        next_pc_s = pc_r + j_imm_s;
      end
      OP_BRANCH: begin
        if (pred_r) begin
          next_pc_s = pc_r + b_imm_s;
        end else begin
          next_pc_s = pc_r + 32'd4;
        end
      end
      default: begin
        next_pc_s = pc_r + 32'd4;
      end
    endcase
  end

  // Fetch sequencing: freeze, redirect handling, then the normal walk.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    inst_s     = inst_r;
    pred_s     = pred_r;
    req_en_s   = 1'b0;
    req_addr_s = req_addr_r;
    query_en_s = 1'b0;
    query_pc_s = query_pc_r;
    out_en_s   = 1'b0;
    out_inst_s = out_inst_r;
    out_pc_s   = out_pc_r;
    out_pred_s = out_pred_r;
    if (!rdy_in) begin
      req_en_s   = req_en_r;
      query_en_s = query_en_r;
      out_en_s   = out_en_r;
    end else if (flush_en) begin
      pc_s = flush_pc;
      case (state_r)
        WAIT_INST, DISCARD_I: state_s = icache_resp_en ? IDLE : DISCARD_I;
        WAIT_PRED, DISCARD_P: state_s = bp_resp_en ? IDLE : DISCARD_P;
        default:              state_s = IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (!downstream_full) begin
            req_en_s   = 1'b1;
            req_addr_s = pc_r;
            state_s    = WAIT_INST;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT_INST: begin
          if (icache_resp_en) begin
            inst_s = icache_resp_inst;
            if (icache_resp_inst[6:0] == OP_BRANCH) begin
              query_en_s = 1'b1;
              query_pc_s = pc_r;
              pred_s     = 1'b0;
              state_s    = WAIT_PRED;
            end else begin
              pred_s  = (icache_resp_inst[6:0] == OP_JAL);
              state_s = OUTPUT;
            end
          end else begin
            state_s = WAIT_INST;
          end
        end
        WAIT_PRED: begin
          if (bp_resp_en) begin
            pred_s  = bp_resp_taken;
            state_s = OUTPUT;
          end else begin
            state_s = WAIT_PRED;
          end
        end
        OUTPUT: begin
          if (!downstream_full) begin
            out_en_s   = 1'b1;
            out_inst_s = inst_r;
            out_pc_s   = pc_r;
            out_pred_s = pred_r;
            pc_s       = next_pc_s;
            state_s    = IDLE;
          end else begin
            state_s = OUTPUT;
          end
        end
        DISCARD_I: state_s = icache_resp_en ? IDLE : DISCARD_I;
        DISCARD_P: state_s = bp_resp_en ? IDLE : DISCARD_P;
        default:   state_s = IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any in-flight fetch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      inst_r     <= 32'd0;
      pred_r     <= 1'b0;
      req_en_r   <= 1'b0;
      req_addr_r <= 32'd0;
      query_en_r <= 1'b0;
      query_pc_r <= 32'd0;
      out_en_r   <= 1'b0;
      out_inst_r <= 32'd0;
      out_pc_r   <= 32'd0;
      out_pred_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      inst_r     <= inst_s;
      pred_r     <= pred_s;
      req_en_r   <= req_en_s;
      req_addr_r <= req_addr_s;
      query_en_r <= query_en_s;
      query_pc_r <= query_pc_s;
      out_en_r   <= out_en_s;
      out_inst_r <= out_inst_s;
      out_pc_r   <= out_pc_s;
      out_pred_r <= out_pred_s;
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized bench for instruction_fetcher. The bench plays icache and branch
// predictor; programs are generated as (kind, offset) pairs per address, and a
// transaction-level model predicts every request, query and delivered
// instruction, cycle by cycle.
module tb_instruction_fetcher;

  localparam int K_OTHER = 0;
  localparam int K_JAL   = 1;
  localparam int K_BR    = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        icache_req_en;
  logic [31:0] icache_req_addr;
  logic        icache_resp_en;
  logic [31:0] icache_resp_inst;
  logic        bp_query_en;
  logic [31:0] bp_query_pc;
  logic        bp_resp_en;
  logic        bp_resp_taken;
  logic        downstream_full;
  logic        inst_out_en;
  logic [31:0] inst_out;
  logic [31:0] inst_out_pc;
  logic        inst_out_pred_taken;
  logic        flush_en;
  logic [31:0] flush_pc;

  instruction_fetcher dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .icache_req_en(icache_req_en), .icache_req_addr(icache_req_addr),
    .icache_resp_en(icache_resp_en), .icache_resp_inst(icache_resp_inst),
    .bp_query_en(bp_query_en), .bp_query_pc(bp_query_pc),
    .bp_resp_en(bp_resp_en), .bp_resp_taken(bp_resp_taken),
    .downstream_full(downstream_full),
    .inst_out_en(inst_out_en), .inst_out(inst_out), .inst_out_pc(inst_out_pc),
    .inst_out_pred_taken(inst_out_pred_taken),
    .flush_en(flush_en), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        live;
  int          phase;      // 0 await inst, 1 await prediction, 2 ready, 3 emitted
  logic [31:0] t_pc;
  int          t_kind;
  int          t_off;
  logic        t_pred;
  logic        req_due, qry_due, out_due;
  logic        ipend, bpend, btaken;
  int          ilat, blat;
  logic [31:0] iaddr;
  // stimulus knobs
  int          p_flush, p_full, p_rdy_low, max_lat;
  logic        flush_once;
  logic        abort;
  int          idle, outs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hash_addr(input logic [31:0] a);
    logic [31:0] h;
    h = (a >> 2) * 32'h9E37_79B1;
    h = h ^ (h >> 16);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    return h;
  endfunction

  function automatic logic is_fixed(input logic [31:0] a);
    return (a < 32'h28) || (a == 32'h100);
  endfunction

  function automatic int mem_kind(input logic [31:0] a);
    logic [31:0] h;
    int k;
    h = hash_addr(a);
    if (a == 32'h10) k = K_JAL;
    else if (a == 32'h20) k = K_BR;
    else if (is_fixed(a)) k = K_OTHER;
    else if (h[31:30] == 2'd1) k = K_JAL;
    else if (h[31:30] == 2'd2) k = K_BR;
    else k = K_OTHER;
    return k;
  endfunction

  function automatic int mem_off(input logic [31:0] a);
    logic [31:0] h;
    int o;
    h = hash_addr(a);
    if (a == 32'h10) o = 8;
    else if (a == 32'h20) o = -16;
    else if (mem_kind(a) == K_JAL) o = (int'(h[27:10]) - 131072) * 4;
    else if (mem_kind(a) == K_BR) o = (int'(h[20:10]) - 1024) * 4;
    else o = 0;
    return o;
  endfunction

  // Encode the instruction word for an address from its kind and offset.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h, im, w;
    logic [6:0]  op;
    h  = hash_addr(a);
    im = mem_off(a);
    case (h[2:0])
      3'd0:    op = 7'b0010011;
      3'd1:    op = 7'b0110011;
      3'd2:    op = 7'b1100111;
      3'd3:    op = 7'b0000011;
      default: op = 7'b0110111;
    endcase
    if (mem_kind(a) == K_JAL)
      w = {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
    else if (mem_kind(a) == K_BR)
      w = {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], 7'b1100011};
    else if (is_fixed(a))
      w = 32'h0000_0013;
    else
      w = {h[31:7], op};
    return w;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input int kind,
                                             input int off, input logic taken);
    logic [31:0] offv;
    offv = off;
    if (kind == K_JAL) return pc + offv;
    if (kind == K_BR && taken) return pc + offv;
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; live = 1'b0; phase = 0; t_pred = 1'b0;
    req_due = 1'b0; qry_due = 1'b0; out_due = 1'b0;
    ipend = 1'b0; bpend = 1'b0; ilat = 0; blat = 0; idle = 0;
  endtask

  task automatic do_reset();
    #3;
    rst_in = 1'b1;
    #1;
    check("rst_en", {29'd0, icache_req_en, bp_query_en, inst_out_en}, 32'd0);
    check("rst_req_addr", icache_req_addr, 32'd0);
    check("rst_qry_pc", bp_query_pc, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_inst_pc", inst_out_pc, 32'd0);
    check("rst_pred", {31'd0, inst_out_pred_taken}, 32'd0);
    rdy_in = 1'b0; flush_en = 1'b0; downstream_full = 1'b0;
    icache_resp_en = 1'b0; bp_resp_en = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model over the edge.
  task automatic step();
    logic n_req, n_qry, n_out, iv, bv;
    @(posedge clk_in);
    #1;
    rdy_in          = ($urandom_range(99) >= p_rdy_low);
    downstream_full = ($urandom_range(99) < p_full);
    flush_en        = ($urandom_range(99) < p_flush);
    flush_pc        = ($urandom_range(3) == 0) ? 32'h100 : ($urandom() & 32'hFFFF_FFFC);
    #1;
    if (rdy_in) begin
      check("req_en", {31'd0, icache_req_en}, {31'd0, req_due});
      if (icache_req_en && req_due) begin
        check("req_addr", icache_req_addr, m_pc);
        live = 1'b1; phase = 0; t_pc = m_pc;
        ipend = 1'b1; iaddr = m_pc; ilat = $urandom_range(max_lat);
        if (flush_once) begin
          flush_once = 1'b0; flush_en = 1'b1; flush_pc = 32'h100; ilat = 2;
        end
      end
      check("qry_en", {31'd0, bp_query_en}, {31'd0, qry_due});
      if (bp_query_en && qry_due) begin
        check("qry_pc", bp_query_pc, t_pc);
        bpend = 1'b1; blat = $urandom_range(max_lat); btaken = 1'($urandom_range(1));
      end
      check("out_en", {31'd0, inst_out_en}, {31'd0, out_due});
      if (inst_out_en && out_due) begin
        check("out_pc", inst_out_pc, t_pc);
        check("out_inst", inst_out, mem_word(t_pc));
        check("out_pred", {31'd0, inst_out_pred_taken}, {31'd0, t_pred});
        m_pc = model_next(t_pc, t_kind, t_off, t_pred);
        live = 1'b0; phase = 0; outs++; idle = 0;
      end
    end else begin
      check("frozen_en", {29'd0, icache_req_en, bp_query_en, inst_out_en}, 32'd0);
    end
    icache_resp_en   = ipend && (ilat == 0);
    icache_resp_inst = icache_resp_en ? mem_word(iaddr) : $urandom();
    bp_resp_en       = bpend && (blat == 0);
    bp_resp_taken    = bp_resp_en ? btaken : 1'($urandom_range(1));
    if (rdy_in) begin
      iv = icache_resp_en;
      bv = bp_resp_en;
      n_out = live && (phase == 2) && !flush_en && !downstream_full;
      n_qry = live && (phase == 0) && iv && !flush_en && (mem_kind(t_pc) == K_BR);
      n_req = !live && !ipend && !bpend && !flush_en && !downstream_full;
      if (iv) ipend = 1'b0;
      if (bv) bpend = 1'b0;
      if (flush_en) begin
        m_pc = flush_pc;
        live = 1'b0;
      end else if (live) begin
        if (phase == 0 && iv) begin
          t_kind = mem_kind(t_pc);
          t_off  = mem_off(t_pc);
          t_pred = (t_kind == K_JAL);
          phase  = (t_kind == K_BR) ? 1 : 2;
        end else if (phase == 1 && bv) begin
          t_pred = btaken;
          phase  = 2;
        end else if (n_out) begin
          phase = 3;
        end
      end
      req_due = n_req; qry_due = n_qry; out_due = n_out;
    end
    if (ipend && ilat > 0) ilat--;
    if (bpend && blat > 0) blat--;
    idle++;
    if (idle > 400) begin
      check("stall_cycles", idle, 32'd0);
      abort = 1'b1;
    end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b0; downstream_full = 1'b0; flush_en = 1'b0;
    flush_pc = 32'h0; icache_resp_en = 1'b0; icache_resp_inst = 32'h0;
    bp_resp_en = 1'b0; bp_resp_taken = 1'b0; btaken = 1'b0; iaddr = 32'h0;
    t_pc = 32'h0; t_kind = K_OTHER; t_off = 0;
    abort = 1'b0; outs = 0; flush_once = 1'b0;
    model_reset();
    #1;
    do_reset();
    // clean run through the fixed program at 0x0
    p_flush = 0; p_full = 0; p_rdy_low = 0; max_lat = 1;
    for (int i = 0; i < 80 && !abort; i++) step();
    // redirect while a fetch is in flight
    flush_once = 1'b1;
    for (int i = 0; i < 40 && !abort; i++) step();
    // mixed back-pressure, stalls and redirects
    p_flush = 5; p_full = 40; p_rdy_low = 25; max_lat = 3;
    for (int i = 0; i < 3000 && !abort; i++) step();
    do_reset();
    p_flush = 0; p_full = 0; p_rdy_low = 0; max_lat = 1;
    for (int i = 0; i < 60 && !abort; i++) step();
    p_flush = 8; p_full = 30; p_rdy_low = 20; max_lat = 3;
    for (int i = 0; i < 2000 && !abort; i++) step();
    check("outputs_seen", {31'd0, outs > 100}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rdy_in  input  1  global ready; low freezes the block.
REQ-005 SHALL have port icache_req_en  output  1  one-cycle fetch request to the icache.
REQ-006 SHALL have port icache_req_addr  output  32  fetch address, valid with icache_req_en.
REQ-007 SHALL have port icache_resp_en  input  1  icache data valid.
REQ-008 SHALL have port icache_resp_inst  input  32  fetched instruction.
REQ-009 SHALL have port bp_query_en  output  1  one-cycle query to the branch predictor.
REQ-010 SHALL have port bp_query_pc  output  32  PC of the queried branch.
REQ-011 SHALL have port bp_resp_en  input  1  predictor answer valid.
REQ-012 SHALL have port bp_resp_taken  input  1  1 = predicted taken.
REQ-013 SHALL have port downstream_full  input  1  issue queue cannot accept this cycle.
REQ-014 SHALL have port inst_out_en  output  1  one-cycle valid for the fetched instruction.
REQ-015 SHALL have port inst_out  output  32  instruction word.
REQ-016 SHALL have port inst_out_pc  output  32  instruction PC.
REQ-017 SHALL have port inst_out_pred_taken  output  1  prediction used (JAL = 1).
REQ-018 SHALL have port flush_en  input  1  RoB mispredict/redirect.
REQ-019 SHALL have port flush_pc  input  32  redirect target.

Function
REQ-020 SHALL implement states IDLE, WAIT_INST, WAIT_PRED, OUTPUT, DISCARD_I, DISCARD_P.
REQ-021 IDLE: when downstream_full=0, SHALL pulse icache_req_en with icache_req_addr=pc and go to WAIT_INST; otherwise SHALL stay in IDLE.
REQ-022 WAIT_INST: on icache_resp_en, SHALL latch the instruction; opcode 7'b1100011 -> pulse bp_query_en with bp_query_pc=pc and go to WAIT_PRED; all other opcodes -> go to OUTPUT.
REQ-023 Next PC SHALL be: JAL (7'b1101111) pc+J-imm, pred_taken=1; branch pc+B-imm if taken, else pc+4; all others, including JALR, pc+4 with pred_taken=0.
REQ-024 Immediates SHALL be sign-extended to 32 bits; PC adds SHALL wrap modulo 2^32.
REQ-025 WAIT_PRED: on bp_resp_en, SHALL record bp_resp_taken and go to OUTPUT.
REQ-026 OUTPUT: when downstream_full=0, SHALL pulse inst_out_en with the latched instruction, PC and prediction, load pc with the next PC, and go to IDLE; otherwise SHALL hold.
REQ-027 All *_en outputs SHALL be single-cycle pulses, and at most one fetch SHALL be outstanding.
REQ-028 flush_en SHALL have priority over all other events: pc<=flush_pc and no inst_out_en that cycle.
REQ-029 On flush_en, the next state SHALL be DISCARD_I from WAIT_INST, DISCARD_P from WAIT_PRED, and IDLE otherwise.
REQ-030 A response arriving in the same cycle as flush_en SHALL be dropped, and the next state SHALL then be IDLE.
REQ-031 DISCARD_I/DISCARD_P SHALL drop the next icache_resp_en/bp_resp_en respectively, then go to IDLE.
REQ-032 flush_en arriving in a DISCARD state SHALL update pc and leave the state unchanged.
REQ-033 While rdy_in=0, SHALL change no state, ignore responses and flush, and drive all *_en outputs to 0.

Reset
REQ-034 While rst_in=1, SHALL immediately set pc=RESET_PC and state=IDLE.
REQ-035 While rst_in=1, SHALL drive all *_en outputs and inst_out_pred_taken to 0, and all data outputs to 0.
REQ-036 Reset mid-transaction SHALL abandon any in-flight request without draining.

Verification
REQ-037 Reset, then icache returns 32'h00000013 at 0x0 -> inst_out_en with inst_out_pc=0x0 and pred_taken=0; next icache_req_addr=0x4.
REQ-038 Instruction at 0x10 = JAL +8 -> no bp_query_en; pred_taken=1; next fetch at 0x18.
REQ-039 BEQ at 0x20 with offset -16: bp_resp_taken=1 -> next fetch 0x10; bp_resp_taken=0 -> next fetch 0x24.
REQ-040 flush_en with flush_pc=0x100 while in WAIT_INST -> the late icache response is dropped with no inst_out_en; next fetch is at 0x100.
REQ-041 downstream_full=1 for 3 cycles in OUTPUT -> inst_out_en fires once, on the first cycle after full deasserts.
REQ-042 rdy_in=0 for 2 cycles during WAIT_PRED with bp_resp_en held -> the answer is accepted only once rdy_in=1.
